// File: rtl/fclass_gen_pkg.sv
// -----------------------------------------------------------------------------
// fclass_gen_pkg
// Shared definitions for the FP-class operand generator:
//   - class bit indices, in the same order as the classify result word
//   - IEEE-754 single-precision exponent constant
//   - FSM state encoding
//   - 23-bit Fibonacci LFSR taps and step function
//   - mask scanning helpers (highest set bit, next lower set bit)
// -----------------------------------------------------------------------------
package fclass_gen_pkg;

  localparam int NUM_CLASSES = 10;

  localparam logic [3:0] CLS_NEG_INF    = 4'd9;
  localparam logic [3:0] CLS_NEG_NORMAL = 4'd8;
  localparam logic [3:0] CLS_NEG_SUB    = 4'd7;
  localparam logic [3:0] CLS_NEG_ZERO   = 4'd6;
  localparam logic [3:0] CLS_POS_ZERO   = 4'd5;
  localparam logic [3:0] CLS_POS_SUB    = 4'd4;
  localparam logic [3:0] CLS_POS_NORMAL = 4'd3;
  localparam logic [3:0] CLS_POS_INF    = 4'd2;
  localparam logic [3:0] CLS_SNAN       = 4'd1;
  localparam logic [3:0] CLS_QNAN       = 4'd0;

  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int LFSR_W      = 23;
  localparam int LFSR_TAP_HI = 22;
  localparam int LFSR_TAP_LO = 17;

  // Result of a mask scan: found flag plus the selected class index.
  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } sel_t;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] r);
    return {r[LFSR_W-2:0], r[LFSR_TAP_HI] ^ r[LFSR_TAP_LO]};
  endfunction

  // Highest set bit of the class mask.
  function automatic sel_t highest_set(input logic [NUM_CLASSES-1:0] mask);
    sel_t s;
    s = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (mask[i]) begin
        s.found = 1'b1;
        s.idx   = 4'(i);
      end
    end
    return s;
  endfunction

  // Highest set bit strictly below idx (ascending scan, last hit wins).
  function automatic sel_t lower_set(input logic [NUM_CLASSES-1:0] mask,
                                     input logic [3:0] idx);
    sel_t s;
    s = '0;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (mask[i] && (i < int'(idx))) begin
        s.found = 1'b1;
        s.idx   = 4'(i);
      end
    end
    return s;
  endfunction

endpackage

// File: rtl/fclass_gen_lfsr.sv
// -----------------------------------------------------------------------------
// fclass_lfsr23
// 23-bit Fibonacci LFSR, r_next = {r[21:0], r[22]^r[17]}.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset (state -> 1)
//   load_i    - load seed_i (takes priority over en_i)
//   seed_i    - load value; the caller guarantees it is nonzero
//   en_i      - advance one step
//   state_o   - current LFSR state
// -----------------------------------------------------------------------------
module fclass_lfsr23
  import fclass_gen_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [LFSR_W-1:0] seed_i,
  input  logic              en_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i)    lfsr_d = seed_i;
    else if (en_i) lfsr_d = lfsr_step(lfsr_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= LFSR_W'(1);
    else     lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/fclass_gen.sv
// -----------------------------------------------------------------------------
// fclass_gen
// Emits single-precision operands of the requested IEEE-754 classes over a
// valid/ready stream, each paired with the one-hot class word a classifier
// must return for it. Classes are visited from the highest set mask bit down,
// COUNT_PER_CLASS operands each.
//
// Ports:
//   clk, rst     - clock, asynchronous active-high reset
//   start        - one-cycle request, sampled only in IDLE
//   class_mask   - classes to generate ([9] -inf ... [0] qNaN)
//   repeat_mode  - (only with FCLASS_GEN_REPEAT_EN) loop the pass instead of
//                  finishing
//   out_valid    - operand valid
//   out_ready    - consumer accepts
//   out_frs      - generated operand
//   out_class    - expected one-hot class word
//   busy         - high outside IDLE
//   done         - one-cycle pulse at end of run
//
// Stream handshake: a transfer happens on every rising edge where out_valid
// and out_ready are both high; out_frs/out_class are held unchanged while
// out_valid is high and out_ready is low.
//
// Optional feature macro: FCLASS_GEN_REPEAT_EN.
// -----------------------------------------------------------------------------
module fclass_gen
  import fclass_gen_pkg::*;
#(
  parameter int                XLEN            = 32,
  parameter int                EXPWIDTH        = 8,
  parameter int                SIGWIDTH        = 24,
  parameter int                COUNT_PER_CLASS = 4,
  parameter logic [LFSR_W-1:0] LFSR_SEED       = 23'h000001
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CLASSES-1:0]       class_mask,
`ifdef FCLASS_GEN_REPEAT_EN
  input  logic                         repeat_mode,
`endif
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [EXPWIDTH+SIGWIDTH-1:0] out_frs,
  output logic [XLEN-1:0]              out_class,
  output logic                         busy,
  output logic                         done
);

  localparam int FW = EXPWIDTH + SIGWIDTH;
  localparam int CNT_W = (COUNT_PER_CLASS > 1) ? $clog2(COUNT_PER_CLASS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT_PER_CLASS - 1);
  localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

  // Normal exponent from the top LFSR byte, kept clear of 0 and all-ones.
  function automatic logic [7:0] normal_exp(input logic [LFSR_W-1:0] r);
    logic [7:0] e;
    e = r[22:15];
    if (e == 8'h00)             e = 8'h01;
    else if (e == EXP_ALL_ONES) e = 8'hFE;
    return e;
  endfunction

  function automatic logic [FW-1:0] build_operand(input logic [3:0] idx,
                                                  input logic [LFSR_W-1:0] r);
    logic        sign;
    logic [7:0]  expo;
    logic [22:0] frac;
    sign = 1'b0;
    expo = 8'h00;
    frac = '0;
    case (idx)
      CLS_NEG_INF:    begin sign = 1'b1; expo = EXP_ALL_ONES; end
      CLS_NEG_NORMAL: begin sign = 1'b1; expo = normal_exp(r); frac = r; end
      CLS_NEG_SUB:    begin sign = 1'b1; frac = r; end
      CLS_NEG_ZERO:   begin sign = 1'b1; end
      CLS_POS_ZERO:   begin sign = 1'b0; end
      CLS_POS_SUB:    begin frac = r; end
      CLS_POS_NORMAL: begin expo = normal_exp(r); frac = r; end
      CLS_POS_INF:    begin expo = EXP_ALL_ONES; end
      CLS_SNAN: begin
        sign = r[0];
        expo = EXP_ALL_ONES;
        frac = {1'b0, r[21:0]};
        // Quiet bit is clear, so a zero payload would read as infinity.
        if (r[21:0] == '0) frac[0] = 1'b1;
      end
      CLS_QNAN: begin
        sign = r[0];
        expo = EXP_ALL_ONES;
        frac = {1'b1, r[21:0]};
      end
      default: ;
    endcase
    return FW'({sign, expo, frac});
  endfunction

  state_e                 state_q, state_d;
  logic [NUM_CLASSES-1:0] mask_q, mask_d;
  logic [3:0]             idx_q, idx_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [FW-1:0]          frs_q, frs_d;
  logic [XLEN-1:0]        cls_q, cls_d;
  logic                   lfsr_load, lfsr_en;
  logic [LFSR_W-1:0]      lfsr_r, lfsr_nxt;
  logic                   rpt;
  sel_t                   hi_sel, lo_sel, hi_mask_sel;

`ifdef FCLASS_GEN_REPEAT_EN
  assign rpt = repeat_mode;
`else
  assign rpt = 1'b0;
`endif

  fclass_lfsr23 u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .load_i  (lfsr_load),
    .seed_i  (SEED_EFF),
    .en_i    (lfsr_en),
    .state_o (lfsr_r)
  );

  assign hi_sel      = highest_set(class_mask);
  assign hi_mask_sel = highest_set(mask_q);
  assign lo_sel      = lower_set(mask_q, idx_q);

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    lfsr_load = 1'b0;
    lfsr_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (class_mask != '0) begin
            mask_d    = class_mask;
            idx_d     = hi_sel.idx;
            cnt_d     = '0;
            lfsr_load = 1'b1;
            state_d   = ST_EMIT;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          lfsr_en = 1'b1;
          if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            if (lo_sel.found) idx_d = lo_sel.idx;
            else if (rpt)     idx_d = hi_mask_sel.idx;
            else              state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The output register always holds the operand for the LFSR value that
  // will be current next cycle, so it is refreshed only when the LFSR moves.
  always_comb begin
    lfsr_nxt = lfsr_r;
    if (lfsr_load)    lfsr_nxt = SEED_EFF;
    else if (lfsr_en) lfsr_nxt = lfsr_step(lfsr_r);
    frs_d = frs_q;
    cls_d = cls_q;
    if (lfsr_load || lfsr_en) begin
      frs_d = build_operand(idx_d, lfsr_nxt);
      cls_d = XLEN'(1) << idx_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mask_q  <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      frs_q   <= '0;
      cls_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      frs_q   <= frs_d;
      cls_q   <= cls_d;
    end
  end

  assign out_valid = (state_q == ST_EMIT);
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign out_frs   = frs_q;
  assign out_class = cls_q;

endmodule

// File: tb/tb_fclass_gen.sv
module tb_fclass_gen;

  localparam int CPC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [9:0]  class_mask = '0;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [31:0] out_frs;
  logic [31:0] out_class;
  logic        busy;
  logic        done;
`ifdef FCLASS_GEN_REPEAT_EN
  logic        repeat_mode = 1'b0;
`endif

  fclass_gen dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .class_mask (class_mask),
`ifdef FCLASS_GEN_REPEAT_EN
    .repeat_mode(repeat_mode),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_frs    (out_frs),
    .out_class  (out_class),
    .busy       (busy),
    .done       (done)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];          // {expected class, expected operand}
  int          hs_cnt = 0;
  int          done_cnt = 0;
  logic        mon_en = 1'b0;
  logic        rand_ready = 1'b0;
  logic [31:0] first_frs = '0;
  logic        stall_prev = 1'b0;
  logic [31:0] frs_prev = '0;
  logic [31:0] cls_prev = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int unsigned m_step(input int unsigned r);
    return ((r << 1) & 32'h7FFFFF) | (((r >> 22) ^ (r >> 17)) & 1);
  endfunction

  function automatic logic [31:0] m_operand(input int idx, input int unsigned r);
    int unsigned s, e, f;
    s = 0; e = 0; f = 0;
    case (idx)
      9: begin s = 1; e = 255; end
      2: begin e = 255; end
      6: s = 1;
      5: s = 0;
      7: begin s = 1; f = r; end
      4: f = r;
      8, 3: begin
        s = (idx == 8) ? 1 : 0;
        e = (r / 32768) % 256;
        if (e == 0) e = 1;
        if (e == 255) e = 254;
        f = r;
      end
      1: begin s = r % 2; e = 255; f = r % (2**22); if (f == 0) f = 1; end
      0: begin s = r % 2; e = 255; f = (r % (2**22)) + 2**22; end
      default: ;
    endcase
    return (s << 31) | (e << 23) | f;
  endfunction

  // Independent classifier: what an FCLASS unit returns for an operand.
  function automatic logic [31:0] m_classify(input logic [31:0] v);
    int unsigned e, f, s;
    int c;
    s = v >> 31;
    e = (v >> 23) & 255;
    f = v & 32'h7FFFFF;
    if (e == 255) begin
      if (f == 0) c = s ? 9 : 2;
      else if (f >= 2**22) c = 0;
      else c = 1;
    end else if (e == 0) begin
      if (f == 0) c = s ? 6 : 5;
      else c = s ? 7 : 4;
    end else begin
      c = s ? 8 : 3;
    end
    return 32'(2**c);
  endfunction

  task automatic build_expected(input logic [9:0] m);
    int unsigned r;
    r = 1;
    for (int idx = 9; idx >= 0; idx--) begin
      if (m[idx]) begin
        for (int k = 0; k < CPC; k++) begin
          exp_q.push_back({32'(2**idx), m_operand(idx, r)});
          r = m_step(r);
        end
      end
    end
  endtask

  // ---------------- ready driver ----------------
  always @(posedge clk) begin
    #1;
    out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      logic [63:0] e;
      if (stall_prev && out_valid) begin
        check("stable_frs", out_frs, frs_prev);
        check("stable_cls", out_class, cls_prev);
      end
      stall_prev = out_valid && !out_ready;
      frs_prev   = out_frs;
      cls_prev   = out_class;
      if (out_valid && out_ready) begin
        if (hs_cnt == 0) first_frs = out_frs;
        hs_cnt++;
        if (exp_q.size() == 0) begin
          check("extra_operand", {out_class, out_frs}, 64'h0);
        end else begin
          e = exp_q.pop_front();
          check("frs", out_frs, e[31:0]);
          check("class", out_class, e[63:32]);
          check("classify", m_classify(out_frs), out_class);
        end
      end
      if (done) begin
        done_cnt++;
        check("busy_with_done", busy, 1);
        check("valid_in_done", out_valid, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start(input logic [9:0] m);
    @(posedge clk); #1;
    start = 1'b1;
    class_mask = m;
    @(posedge clk); #1;
    start = 1'b0;
    class_mask = 10'($urandom);   // latched mask must ignore this
  endtask

  task automatic run(input logic [9:0] m, input int exp_hs, input bit glitch);
    int d0;
    bit got;
    hs_cnt = 0;
    d0 = done_cnt;
    pulse_start(m);
    if (glitch) begin
      repeat (3) @(posedge clk);
      #1; start = 1'b1; class_mask = 10'h001;
      @(posedge clk); #1; start = 1'b0;
    end
    got = 0;
    for (int c = 0; c < 3000 && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check("run_done_seen", got, 1);
    check("queue_drained", exp_q.size(), 0);
    check("handshakes", hs_cnt, exp_hs);
    @(negedge clk);
    check("done_pulses", done_cnt - d0, 1);
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("valid_after_done", out_valid, 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [9:0] rm;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_frs", out_frs, 0);
    check("rst_class", out_class, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // -inf only
    for (int k = 0; k < CPC; k++) exp_q.push_back({32'h200, 32'hFF800000});
    run(10'h200, CPC, 0);

    // +subnormal walks the LFSR
    exp_q.push_back({32'h010, 32'h00000001});
    exp_q.push_back({32'h010, 32'h00000002});
    exp_q.push_back({32'h010, 32'h00000004});
    exp_q.push_back({32'h010, 32'h00000008});
    run(10'h010, 4, 0);

    // NaN payload construction
    build_expected(10'h001);
    run(10'h001, CPC, 0);
    check("qnan_first", first_frs, 32'hFFC00001);
    build_expected(10'h002);
    run(10'h002, CPC, 0);
    check("snan_first", first_frs, 32'hFF800001);

    // empty mask: straight to DONE
    pulse_start(10'h000);
    @(negedge clk);
    check("m0_done", done, 1);
    check("m0_busy", busy, 1);
    check("m0_valid", out_valid, 0);
    @(negedge clk);
    check("m0_done_clear", done, 0);
    check("m0_idle", busy, 0);

    // all classes with backpressure, plus a start pulse while busy
    rand_ready = 1'b1;
    build_expected(10'h3FF);
    run(10'h3FF, 10 * CPC, 1);

    for (int t = 0; t < 3; t++) begin
      rm = 10'($urandom_range(1, 1023));
      build_expected(rm);
      run(rm, $countones(rm) * CPC, 0);
    end

    // asynchronous reset in the middle of EMIT
    build_expected(10'h3FF);
    pulse_start(10'h3FF);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid", out_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    mon_en = 1'b0;
    exp_q.delete();
    stall_prev = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    rand_ready = 1'b0;
    mon_en = 1'b1;
    exp_q.push_back({32'h010, 32'h00000001});
    exp_q.push_back({32'h010, 32'h00000002});
    exp_q.push_back({32'h010, 32'h00000004});
    exp_q.push_back({32'h010, 32'h00000008});
    run(10'h010, 4, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
